// File: rtl/snake_engine.sv
// snake_engine: game-logic core for a snake on a GRID_W x GRID_H board.
// Holds the body as MAX_LEN position slots (slot 0 = head), moves one cell per
// step pulse, handles turn keys, food growth, wrap or wall death and self-collision.
//
// Ports:
//   sys_clk      - clock
//   sys_reset_n  - asynchronous reset, ACTIVE HIGH despite the name
//   step         - one-cycle move tick
//   po_data      - key code; sel = po_data[3:0] (4'b0100 = CCW turn, 4'b1000 = CW turn)
//   start        - leave IDLE or DIE (re-initialises the snake)
//   food_pos     - food cell, row*GRID_W+col
//   food_valid   - food_pos is meaningful
//   snake_body   - slot k at [(MAX_LEN-k)*POS_W-1 -: POS_W], head in the MSBs
//   snake_len    - current length
//   dir          - 0=UP 1=DOWN 2=LEFT 3=RIGHT
//   alive        - high while running
//   ate          - one-cycle pulse after a step that consumed food
//   died         - one-cycle pulse on entry to DIE
module snake_engine #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned WRAP     = 1,
    localparam int unsigned POS_W   = $clog2(GRID_W * GRID_H),
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset_n,
    input  logic                     step,
    input  logic [7:0]               po_data,
    input  logic                     start,
    input  logic [POS_W-1:0]         food_pos,
    input  logic                     food_valid,
    output logic [MAX_LEN*POS_W-1:0] snake_body,
    output logic [LEN_W-1:0]         snake_len,
    output logic [1:0]               dir,
    output logic                     alive,
    output logic                     ate,
    output logic                     died
);

    localparam int unsigned INIT_HEAD = (GRID_H - 3) * GRID_W + (GRID_W - INIT_LEN);

    localparam logic [POS_W-1:0] GW     = POS_W'(GRID_W);
    localparam logic [POS_W-1:0] GH     = POS_W'(GRID_H);
    localparam logic [POS_W-1:0] ONE_P  = POS_W'(1);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_IN = LEN_W'(INIT_LEN);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DIE = 2'd2} state_t;
    typedef enum logic [1:0] {T_NONE = 2'd0, T_CCW = 2'd1, T_CW = 2'd2} turn_t;

    state_t           state_q, state_n;
    logic [POS_W-1:0] body_q [MAX_LEN];
    logic [POS_W-1:0] body_n [MAX_LEN];
    logic [LEN_W-1:0] len_q, len_n;
    logic [1:0]       dir_q, dir_n;
    turn_t            pend_q, pend_n;
    logic             alive_q, ate_q, ate_n, died_q, died_n;

    turn_t            key_turn, eff_turn;
    logic [1:0]       step_dir;
    logic [POS_W-1:0] head_row, head_col, new_row, new_col, new_head;
    logic             off_grid, grow, grow_len, hit;
    int unsigned      len_u, new_len_u;

    // Upper key bits carry no meaning for this block.
    logic unused_key_hi;
    assign unused_key_hi = ^po_data[7:4];

    // Initial body: horizontal run starting at INIT_HEAD, empty slots read as 0.
    function automatic logic [POS_W-1:0] init_slot(input int unsigned k);
        return (k < INIT_LEN) ? POS_W'(INIT_HEAD + k) : '0;
    endfunction

    function automatic logic [1:0] turn_dir(input logic [1:0] d, input turn_t t);
        logic [1:0] r;
        r = d;
        case (t)
            T_CCW: begin
                case (d)
                    D_UP:    r = D_LEFT;
                    D_LEFT:  r = D_DOWN;
                    D_DOWN:  r = D_RIGHT;
                    default: r = D_UP;
                endcase
            end
            T_CW: begin
                case (d)
                    D_UP:    r = D_RIGHT;
                    D_RIGHT: r = D_DOWN;
                    D_DOWN:  r = D_LEFT;
                    default: r = D_UP;
                endcase
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state / next-value logic.
    always_comb begin
        state_n = state_q;
        body_n  = body_q;
        len_n   = len_q;
        dir_n   = dir_q;
        pend_n  = pend_q;
        ate_n   = 1'b0;
        died_n  = 1'b0;

        key_turn = T_NONE;
        if (po_data[3:0] == 4'b0100) begin
            key_turn = T_CCW;
        end else if (po_data[3:0] == 4'b1000) begin
            key_turn = T_CW;
        end
        // A key in the step cycle is newer than any pending one.
        eff_turn = (key_turn != T_NONE) ? key_turn : pend_q;
        step_dir = turn_dir(dir_q, eff_turn);

        head_row = body_q[0] / GW;
        head_col = body_q[0] % GW;
        new_row  = head_row;
        new_col  = head_col;
        off_grid = 1'b0;
        case (step_dir)
            D_UP: begin
                if (head_row == '0) begin
                    off_grid = 1'b1;
                    new_row  = GH - ONE_P;
                end else begin
                    new_row = head_row - ONE_P;
                end
            end
            D_DOWN: begin
                if (head_row == GH - ONE_P) begin
                    off_grid = 1'b1;
                    new_row  = '0;
                end else begin
                    new_row = head_row + ONE_P;
                end
            end
            D_LEFT: begin
                if (head_col == '0) begin
                    off_grid = 1'b1;
                    new_col  = GW - ONE_P;
                end else begin
                    new_col = head_col - ONE_P;
                end
            end
            default: begin
                if (head_col == GW - ONE_P) begin
                    off_grid = 1'b1;
                    new_col  = '0;
                end else begin
                    new_col = head_col + ONE_P;
                end
            end
        endcase
        new_head = new_row * GW + new_col;

        grow     = food_valid && (new_head == food_pos);
        grow_len = grow && (len_q < LEN_MX);
        len_u    = 32'(len_q);

        // The tail slot vacates on a plain move, but stays occupied when the snake grows.
        hit = 1'b0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if ((body_q[k] == new_head) &&
                ((k + 32'd2 <= len_u) || (grow_len && (k + 32'd1 == len_u)))) begin
                hit = 1'b1;
            end
        end

        new_len_u = grow_len ? len_u + 32'd1 : len_u;

        case (state_q)
            S_IDLE, S_DIE: begin
                if (start) begin
                    state_n = S_RUN;
                    for (int unsigned k = 0; k < MAX_LEN; k++) begin
                        body_n[k] = init_slot(k);
                    end
                    len_n  = LEN_IN;
                    dir_n  = D_LEFT;
                    pend_n = T_NONE;
                end
            end
            S_RUN: begin
                if (key_turn != T_NONE) begin
                    pend_n = key_turn;
                end
                if (step) begin
                    pend_n = T_NONE;
                    if (off_grid && (WRAP == 0)) begin
                        state_n = S_DIE;
                        died_n  = 1'b1;
                    end else begin
                        dir_n = step_dir;
                        if (hit) begin
                            state_n = S_DIE;
                            died_n  = 1'b1;
                        end else begin
                            body_n[0] = new_head;
                            for (int unsigned k = 1; k < MAX_LEN; k++) begin
                                body_n[k] = (k < new_len_u) ? body_q[k-1] : '0;
                            end
                            len_n = grow_len ? len_q + ONE_L : len_q;
                            ate_n = grow;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_reset_n) begin
        if (sys_reset_n) begin
            state_q <= S_IDLE;
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                body_q[k] <= init_slot(k);
            end
            len_q   <= LEN_IN;
            dir_q   <= D_LEFT;
            pend_q  <= T_NONE;
            alive_q <= 1'b0;
            ate_q   <= 1'b0;
            died_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            body_q  <= body_n;
            len_q   <= len_n;
            dir_q   <= dir_n;
            pend_q  <= pend_n;
            alive_q <= (state_n == S_RUN);
            ate_q   <= ate_n;
            died_q  <= died_n;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign snake_body[(MAX_LEN-g)*POS_W-1 -: POS_W] = body_q[g];
    end

    assign snake_len = len_q;
    assign dir       = dir_q;
    assign alive     = alive_q;
    assign ate       = ate_q;
    assign died      = died_q;

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 8, meaning grid columns.
REQ-002 SHALL have parameter GRID_H, default 8, meaning grid rows.
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning the number of body slots.
REQ-004 SHALL have parameter INIT_LEN, default 4, meaning the length after init (2..MAX_LEN).
REQ-005 SHALL have parameter WRAP, default 1, meaning 1 = edges wrap and 0 = an edge exit kills the snake.
REQ-006 SHALL have derived parameter POS_W = clog2(GRID_W*GRID_H); position encoding is row*GRID_W+col.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port sys_reset_n, input, 1 bit: asynchronous, active-high reset (despite its name).
REQ-009 SHALL have port step, input, 1 bit: move tick, a one-cycle pulse.
REQ-010 SHALL have port po_data, input, 8 bits: key code, with sel = po_data[3:0].
REQ-011 SHALL have port start, input, 1 bit: leave IDLE or DIE.
REQ-012 SHALL have port food_pos, input, POS_W bits: food cell.
REQ-013 SHALL have port food_valid, input, 1 bit: food_pos is meaningful.
REQ-014 SHALL have port snake_body, output, MAX_LEN*POS_W bits: slot 0 (head) in the MSBs, slot k at bits [(MAX_LEN-k)*POS_W-1 -: POS_W].
REQ-015 SHALL have port snake_len, output, clog2(MAX_LEN+1) bits: current length.
REQ-016 SHALL have port dir, output, 2 bits: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
REQ-017 SHALL have port alive, output, 1 bit: high in RUN.
REQ-018 SHALL have port ate, output, 1 bit: one-cycle pulse when food is consumed.
REQ-019 SHALL have port died, output, 1 bit: one-cycle pulse on entry to DIE.

Function
REQ-020 SHALL implement states IDLE, RUN and DIE, with IDLE->RUN and DIE->RUN (after re-init) on start; start in RUN SHALL be ignored.
REQ-021 SHALL perform init as follows:
- head at row GRID_H-3, col GRID_W-INIT_LEN;
- slot k = head+k for k<INIT_LEN, slots >= INIT_LEN = 0;
- snake_len = INIT_LEN, dir = LEFT.
REQ-022 SHALL treat sel=4'b0100 as a counter-clockwise turn: UP->LEFT, LEFT->DOWN, DOWN->RIGHT, RIGHT->UP.
REQ-023 SHALL treat sel=4'b1000 as a clockwise turn: UP->RIGHT, RIGHT->DOWN, DOWN->LEFT, LEFT->UP.
REQ-024 SHALL ignore any other sel value.
REQ-025 SHALL latch a turn request as pending until the next step; a newer request SHALL replace it; turns SHALL be latched only in RUN.
REQ-026 SHALL, when a turn and step arrive in the same cycle, apply that turn to that step.
REQ-027 SHALL, on step in RUN, first apply the pending turn to dir (then clear it), then compute the new head from the head and the updated dir; UP = row-1, DOWN = row+1, LEFT = col-1, RIGHT = col+1.
REQ-028 SHALL, with WRAP=1, wrap col 0<->GRID_W-1 and row 0<->GRID_H-1.
REQ-029 SHALL, with WRAP=0, enter DIE on an off-grid move, with body, len and dir unchanged.
REQ-030 SHALL set grow = food_valid and new head == food_pos.
REQ-031 SHALL detect collision when the new head equals any slot 0..len-2, extended to slot len-1 when grow and len<MAX_LEN.
REQ-032 SHALL, on collision, enter DIE with body unchanged.
REQ-033 SHALL, on a legal move, shift slot k <= slot k-1, set slot 0 <= new head, and force slots >= the new length to 0.
REQ-034 SHALL, on grow, increment len, saturating at MAX_LEN (at MAX_LEN the body shifts only), and pulse ate the next cycle even when saturated.
REQ-035 SHALL make all outputs registered, with one cycle of latency from the sampled step to updated snake_body, snake_len and ate.
REQ-036 SHALL ignore step in IDLE and DIE; the body SHALL hold.

Reset
REQ-037 SHALL, on sys_reset_n high (asynchronous), enter IDLE with init values.
REQ-038 SHALL, on reset, clear alive, ate, died and the pending turn.
REQ-039 SHALL abort any in-flight step on reset mid-RUN, with no ate or died pulse.

Verification
REQ-040 SHALL cover init and first move (8x8): reset -> body {44,45,46,47,0...}, len 4, dir LEFT, alive 0; start, then step -> body {43,44,45,46}.
REQ-041 SHALL cover wrap (WRAP=1): head 40 moving LEFT, step -> head 47.
REQ-042 SHALL cover turn+step in the same cycle: head 44 LEFT, sel=4'b1000 with step -> dir UP, head 36.
REQ-043 SHALL cover grow: head 44 LEFT, food_pos=43, food_valid=1, step -> len 5, body {43,44,45,46,47}, ate high for 1 cycle.
REQ-044 SHALL cover self-collision from body {43,44,45,46,47} LEFT, via three 4'b1000 turns each followed by a step:
- heads 35 then 36;
- third step targets 44 -> DIE, died pulse, body {36,35,43,44,45} held, further steps ignored.
REQ-045 SHALL cover wall death (WRAP=0): head 40 moving LEFT, step -> DIE, died pulse, body unchanged; start -> init values, RUN.
